// File: rtl/img_pkg.sv
// Shared types and elaboration-time helpers for the image frame capture block.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } img_state_t;

    // Bits needed to index a range of n values, never less than 1.
    function automatic int img_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int img_pixel_size(input int w, input int h);
        return w * h;
    endfunction

    function automatic int img_beats(input int w, input int h, input int ppb);
        return (w * h) / ppb;
    endfunction

    function automatic int img_samples(input int w, input int h, input int ch);
        return w * h * ch;
    endfunction

endpackage

// File: rtl/img_frame_ram.sv
// Frame buffer: wide write of one beat at a base address, single-sample registered read.
module img_frame_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 24,
    parameter int LANES  = 6,
    parameter int AW     = 5
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_base,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                mem[wr_base + AW'(i)] <= wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Only the output register is reset; stored samples survive reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/image_frame_capture.sv
// Captures one frame from a multi-pixel beat stream into a buffer (optional row
// flip and channel reversal), then drains it as a serial sample stream.
module image_frame_capture
    import img_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int HEIGHT       = 32,
    parameter int PIX_PER_BEAT = 2,
    parameter int CHANNELS     = 3,
    parameter int DATA_W       = 8,
    parameter int ROW_FLIP     = 1,
    parameter int CH_REVERSE   = 1
) (
    input  logic                                   HCLK,
    input  logic                                   HRESET,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_sof,
    input  logic [PIX_PER_BEAT*CHANNELS*DATA_W-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_W-1:0]                      out_data,
    output logic                                   out_last,
    output logic                                   frame_done,
    output logic                                   sof_err,
    output logic [1:0]                             dbg_state
);

    localparam int COLS       = WIDTH / PIX_PER_BEAT;
    localparam int PIXEL_SIZE = img_pixel_size(WIDTH, HEIGHT);
    localparam int SAMPLES    = PIXEL_SIZE * CHANNELS;
    localparam int LANES      = PIX_PER_BEAT * CHANNELS;
    localparam int CW         = img_clog2(COLS);
    localparam int RW         = img_clog2(HEIGHT);
    localparam int AW         = img_clog2(SAMPLES);

    img_state_t            state;
    logic [CW-1:0]         cnt_col;
    logic [RW-1:0]         cnt_row;
    logic [AW-1:0]         rd_addr;

    logic                  accept;
    logic [CW-1:0]         eff_col;
    logic [RW-1:0]         eff_row;
    logic                  last_beat;
    logic                  wr_en;
    logic [AW-1:0]         wr_base;
    logic [LANES*DATA_W-1:0] wr_data;
    logic                  rd_en;
    int                    row_i;

    // Handshake: a beat transfers on a cycle where in_valid && in_ready, a sample
    // on a cycle where out_valid && out_ready; a stalled sample holds its data.
    always_comb begin
        accept    = in_valid && in_ready && (state != DRAIN);
        eff_col   = in_sof ? '0 : cnt_col;
        eff_row   = in_sof ? '0 : cnt_row;
        last_beat = (int'(eff_row) == HEIGHT - 1) && (int'(eff_col) == COLS - 1);
        wr_en     = accept && (in_sof || (state == CAPTURE));
        row_i     = (ROW_FLIP != 0) ? (HEIGHT - 1 - int'(eff_row)) : int'(eff_row);
        wr_base   = AW'((row_i * WIDTH + int'(eff_col) * PIX_PER_BEAT) * CHANNELS);
        wr_data   = '0;
        for (int p = 0; p < PIX_PER_BEAT; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_data[(p*CHANNELS + ((CH_REVERSE != 0) ? (CHANNELS - 1 - c) : c))*DATA_W +: DATA_W]
                    = in_data[(p*CHANNELS + c)*DATA_W +: DATA_W];
            end
        end
        // Fetch the next sample whenever the output register is empty or being consumed.
        rd_en = (state == DRAIN) && (!out_valid || out_ready) && !(out_valid && out_last);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= IDLE;
            cnt_col    <= '0;
            cnt_row    <= '0;
            rd_addr    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, CAPTURE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if ((state == IDLE) && !in_sof) begin
                            sof_err <= 1'b1;
                        end else begin
                            if ((state == CAPTURE) && in_sof) sof_err <= 1'b1;
                            if (last_beat) begin
                                state      <= DRAIN;
                                in_ready   <= 1'b0;
                                frame_done <= 1'b1;
                                cnt_col    <= '0;
                                cnt_row    <= '0;
                                rd_addr    <= '0;
                            end else begin
                                state <= CAPTURE;
                                if (int'(eff_col) == COLS - 1) begin
                                    cnt_col <= '0;
                                    cnt_row <= eff_row + 1'b1;
                                end else begin
                                    cnt_col <= eff_col + 1'b1;
                                    cnt_row <= eff_row;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    in_ready <= 1'b0;
                    if (out_valid && out_ready && out_last) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                    end else if (rd_en) begin
                        out_valid <= 1'b1;
                        out_last  <= (int'(rd_addr) == SAMPLES - 1);
                        rd_addr   <= (int'(rd_addr) == SAMPLES - 1) ? '0 : rd_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    img_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (SAMPLES),
        .LANES  (LANES),
        .AW     (AW)
    ) u_ram (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .wr_en   (wr_en),
        .wr_base (wr_base),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_image_frame_capture.sv
// Directed bench for image_frame_capture: a flipped/reversed instance plus a
// plain-layout instance driven in lockstep from the same stimulus.
module tb_image_frame_capture;

    logic        HCLK;
    logic        HRESET;
    logic        in_valid;
    logic        in_sof;
    logic [47:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid, out_last, frame_done, sof_err;
    logic [7:0]  out_data;
    logic [1:0]  dbg_state;

    logic        b_in_ready, b_out_valid, b_out_last, b_frame_done, b_sof_err;
    logic [7:0]  b_out_data;
    logic [1:0]  b_dbg_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b_q[$];

    image_frame_capture #(
        .WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2), .CHANNELS(3), .DATA_W(8),
        .ROW_FLIP(1), .CH_REVERSE(1)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
        .sof_err(sof_err), .dbg_state(dbg_state)
    );

    image_frame_capture #(
        .WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2), .CHANNELS(3), .DATA_W(8),
        .ROW_FLIP(0), .CH_REVERSE(0)
    ) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sof(in_sof), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .frame_done(b_frame_done),
        .sof_err(b_sof_err), .dbg_state(b_dbg_state)
    );

    // Clock and reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Beat b carries pixels k=2b and 2b+1 with R=k, G=16+k, B=32+k.
    function automatic logic [47:0] make_beat(input int b);
        logic [47:0] d;
        int k;
        d = '0;
        for (int p = 0; p < 2; p++) begin
            k = 2 * b + p;
            d[(p*3 + 0)*8 +: 8] = 8'(k);
            d[(p*3 + 1)*8 +: 8] = 8'(16 + k);
            d[(p*3 + 2)*8 +: 8] = 8'(32 + k);
        end
        return d;
    endfunction

    // Expected drain order: buffer address ascending, address = (row*4+col)*3+slot.
    task automatic fill(input bit flip, input bit rev, input bit to_b);
        int r, c, k;
        for (int br = 0; br < 2; br++) begin
            for (int col = 0; col < 4; col++) begin
                for (int slot = 0; slot < 3; slot++) begin
                    r = flip ? 1 - br : br;
                    c = rev ? 2 - slot : slot;
                    k = r * 4 + col;
                    if (to_b) exp_b_q.push_back(8'(c * 16 + k));
                    else      exp_q.push_back(8'(c * 16 + k));
                end
            end
        end
    endtask

    // Driver: present a beat, wait (bounded) for in_ready, let one edge accept it.
    task automatic send_beat(input bit sof, input logic [47:0] data);
        int waited;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = data;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) chk("beat_ready_timeout", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame();
        for (int b = 0; b < 4; b++) begin
            send_beat(b == 0, make_beat(b));
            if (b < 3) chk("fd_early", 32'(frame_done), 0);
        end
        chk("fd_pulse", 32'(frame_done), 1);
        chk("drain_state", 32'(dbg_state), 2);
        chk("drain_in_ready", 32'(in_ready), 0);
        chk("drain_first_invalid", 32'(out_valid), 0);
        tick();
        chk("fd_clear", 32'(frame_done), 0);
        chk("first_valid", 32'(out_valid), 1);
    endtask

    // Scoreboard drain: pops exp_q on every consumed sample.
    task automatic drain(input bit stall);
        logic [3:0] ready_pat;
        logic [7:0] held, expv;
        bit         stalled;
        int         cyc;
        ready_pat = 4'b1001;
        stalled   = 1'b0;
        held      = '0;
        cyc       = 0;
        while (exp_q.size() > 0 && cyc < 500) begin
            if (stalled) begin
                chk("hold_data", 32'(out_data), 32'(held));
                chk("hold_valid", 32'(out_valid), 1);
            end
            if (stall) chk("bp_in_ready", 32'(in_ready), 0);
            out_ready = stall ? ready_pat[cyc % 4] : 1'b1;
            stalled   = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && out_ready) begin
                expv = exp_q.pop_front();
                chk("drain_data", 32'(out_data), 32'(expv));
                chk("drain_last", 32'(out_last), 32'(exp_q.size() == 0));
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        chk("drain_timeout", 32'(exp_q.size()), 0);
        chk("end_out_valid", 32'(out_valid), 0);
        chk("end_state", 32'(dbg_state), 0);
        chk("end_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        int consumed, cyc;
        HRESET    = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_state", 32'(dbg_state), 0);
        HRESET = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);
        chk("idle_frame_done", 32'(frame_done), 0);
        chk("idle_sof_err", 32'(sof_err), 0);

        // Clean frame, full-rate drain
        out_ready = 1'b1;
        fill(1, 1, 0);
        send_frame();
        chk("clean_first_sample", 32'(out_data), 36);
        drain(0);
        chk("clean_sof_err", 32'(sof_err), 0);

        // Backpressure with out_ready pattern 1,0,0,1
        fill(1, 1, 0);
        send_frame();
        drain(1);
        chk("bp_sof_err", 32'(sof_err), 0);

        // Missing sof in IDLE
        send_beat(1'b0, make_beat(3));
        chk("nosof_err", 32'(sof_err), 1);
        chk("nosof_state", 32'(dbg_state), 0);
        fill(1, 1, 0);
        send_frame();
        drain(0);

        // Mid-frame sof restarts the capture
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        tick();
        chk("mid_sof_err_clear", 32'(sof_err), 0);
        send_beat(1'b1, ~make_beat(0));
        send_beat(1'b0, ~make_beat(1));
        chk("mid_pre_sof_err", 32'(sof_err), 0);
        chk("mid_pre_state", 32'(dbg_state), 1);
        fill(1, 1, 0);
        send_frame();
        chk("mid_sof_err", 32'(sof_err), 1);
        drain(0);

        // Reset during drain, both layouts in lockstep
        fill(1, 1, 0);
        fill(0, 0, 1);
        send_frame();
        consumed = 0;
        cyc      = 0;
        while (consumed < 5 && cyc < 100) begin
            if (out_valid && out_ready) begin
                chk("rstd_data_a", 32'(out_data), 32'(exp_q.pop_front()));
                chk("rstd_data_b", 32'(b_out_data), 32'(exp_b_q.pop_front()));
                consumed++;
            end
            tick();
            cyc++;
        end
        chk("rstd_count", 32'(consumed), 5);
        HRESET = 1'b1;
        tick();
        chk("rstd_out_valid_in_rst", 32'(out_valid), 0);
        HRESET = 1'b0;
        tick();
        chk("rstd_out_valid", 32'(out_valid), 0);
        chk("rstd_in_ready", 32'(in_ready), 1);
        chk("rstd_state", 32'(dbg_state), 0);
        chk("rstd_b_out_valid", 32'(b_out_valid), 0);
        chk("rstd_b_in_ready", 32'(b_in_ready), 1);
        chk("rstd_b_state", 32'(b_dbg_state), 0);
        exp_q.delete();
        exp_b_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
